// File: rtl/note_seq_pkg.sv
// Shared types and the default melody table for the note sequencer.
package note_seq_pkg;

    localparam int ENTRY_W = 7;
    localparam int MAX_LEN = 16;
    localparam int IDX_W   = $clog2(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        PAUSED = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic       tom;
        logic [2:0] notas;
        logic [2:0] dur;
    } note_entry_t;

    // Ascending sweep of all 16 display codes, one beat each.
    function automatic logic [MAX_LEN*ENTRY_W-1:0] default_table();
        logic [MAX_LEN*ENTRY_W-1:0] tbl;
        logic [3:0]                 code;
        tbl = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            code = 4'(i);
            tbl[i*ENTRY_W +: ENTRY_W] = {code, 3'd0};
        end
        return tbl;
    endfunction

endpackage

// File: rtl/note_sequencer_rom.sv
// Combinational 16-entry note table lookup; contents fixed at elaboration.
module note_rom
    import note_seq_pkg::*;
#(
    parameter logic [MAX_LEN*ENTRY_W-1:0] TABLE = default_table()
) (
    input  logic [IDX_W-1:0]   idx,
    output logic [ENTRY_W-1:0] entry
);

    assign entry = TABLE[idx*ENTRY_W +: ENTRY_W];

endmodule

// File: rtl/note_sequencer.sv
// Melody playback engine driving TOM/NOTAS for the note display.
// Define NOTE_SEQ_LOOP_EN to wrap playback to entry 0 instead of stopping.
//
// state   | meaning
// IDLE    | outputs zeroed, waiting for Start
// PLAY    | current entry on outputs, tick/beat counters running
// PAUSED  | current entry held, counters frozen
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int                         TICKS_PER_BEAT = 4,
    parameter int                         SEQ_LEN        = 16,
    parameter logic [MAX_LEN*ENTRY_W-1:0] TABLE          = default_table()
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Pause,
    output logic       TOM,
    output logic [2:0] NOTAS,
    output logic       Note_valid,
    output logic       Busy,
    output logic       Done
);

    localparam logic [1:0]       ST_IDLE   = 2'(IDLE);
    localparam logic [1:0]       ST_PLAY   = 2'(PLAY);
    localparam logic [1:0]       ST_PAUSED = 2'(PAUSED);
    localparam logic [15:0]      TICK_LAST = 16'(TICKS_PER_BEAT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SEQ_LEN - 1);

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        tick_q, tick_d;
    logic [2:0]         beat_q, beat_d;
    logic [2:0]         dur_q;
    logic               done_d;
    logic               active_d;
    logic [ENTRY_W-1:0] rom_word;
    note_entry_t        next_entry;

    // The ROM is addressed with the next index so the outputs can be registered.
    note_rom #(.TABLE(TABLE)) u_rom (
        .idx   (idx_d),
        .entry (rom_word)
    );

    assign next_entry = note_entry_t'(rom_word);
    assign active_d   = (state_d != ST_IDLE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tick_d  = tick_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start && !Stop) begin
                    state_d = ST_PLAY;
                    idx_d   = '0;
                    tick_d  = '0;
                    beat_d  = '0;
                end
            end
            ST_PLAY, ST_PAUSED: begin
                if (Stop) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    tick_d  = '0;
                    beat_d  = '0;
                end else if (Pause) begin
                    state_d = ST_PAUSED;
                end else begin
                    // Leaving PAUSED counts in the same cycle, so only Pause-high cycles are lost.
                    state_d = ST_PLAY;
                    if (tick_q != TICK_LAST) begin
                        tick_d = tick_q + 16'd1;
                    end else begin
                        tick_d = '0;
                        if (beat_q != dur_q) begin
                            beat_d = beat_q + 3'd1;
                        end else begin
                            beat_d = '0;
                            if (idx_q != LAST_IDX) begin
                                idx_d = idx_q + 1'b1;
                            end else begin
                                idx_d  = '0;
                                done_d = 1'b1;
`ifdef NOTE_SEQ_LOOP_EN
                                state_d = ST_PLAY;
`else
                                state_d = ST_IDLE;
`endif
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                tick_d  = '0;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tick_q     <= '0;
            beat_q     <= '0;
            dur_q      <= '0;
            TOM        <= 1'b0;
            NOTAS      <= 3'd0;
            Note_valid <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tick_q     <= tick_d;
            beat_q     <= beat_d;
            dur_q      <= next_entry.dur;
            TOM        <= active_d ? next_entry.tom : 1'b0;
            NOTAS      <= active_d ? next_entry.notas : 3'd0;
            Note_valid <= active_d;
            Busy       <= active_d;
            Done       <= done_d;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed vector tables plus randomized run against a cycle-length model.
module tb_note_sequencer;
    import note_seq_pkg::*;

`ifdef NOTE_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    function automatic logic [111:0] custom_table();
        logic [111:0] t;
        for (int i = 0; i < 16; i++) t[i*7 +: 7] = 7'(i << 3);
        t[2:0] = 3'd3;
        return t;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic       tom_w[3];
    logic [2:0] notas_w[3];
    logic       valid_w[3], busy_w[3], done_w[3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    note_sequencer #(.TICKS_PER_BEAT(2), .SEQ_LEN(16)) dut (
        .Clock(clk), .Reset(rst), .Start(start), .Stop(stop), .Pause(pause),
        .TOM(tom_w[0]), .NOTAS(notas_w[0]), .Note_valid(valid_w[0]), .Busy(busy_w[0]), .Done(done_w[0]));

    note_sequencer #(.TICKS_PER_BEAT(2), .SEQ_LEN(16), .TABLE(custom_table())) dut_c (
        .Clock(clk), .Reset(rst), .Start(start), .Stop(stop), .Pause(pause),
        .TOM(tom_w[1]), .NOTAS(notas_w[1]), .Note_valid(valid_w[1]), .Busy(busy_w[1]), .Done(done_w[1]));

    note_sequencer #(.TICKS_PER_BEAT(1), .SEQ_LEN(3)) dut_s (
        .Clock(clk), .Reset(rst), .Start(start), .Stop(stop), .Pause(pause),
        .TOM(tom_w[2]), .NOTAS(notas_w[2]), .Note_valid(valid_w[2]), .Busy(busy_w[2]), .Done(done_w[2]));

    function automatic logic [6:0] obs(int d);
        return {valid_w[d], busy_w[d], done_w[d], tom_w[d], notas_w[d]};
    endfunction

    task automatic check(input string name, input int d, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual={valid,busy,done,code}=%b required=%b",
                     name, d, $time, act, exp);
        end
    endtask

    // Reference model: a note is simply a run of (dur+1)*tpb unpaused playing cycles.
    int       m_tpb[3] = '{2, 2, 1};
    int       m_len[3] = '{16, 16, 3};
    bit [6:0] m_tbl[3][16];
    bit       m_active[3] = '{0, 0, 0};
    bit       m_done[3] = '{0, 0, 0};
    int       m_idx[3] = '{0, 0, 0};
    int       m_el[3] = '{0, 0, 0};

    initial begin
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 16; i++) m_tbl[d][i] = 7'(i << 3);
        m_tbl[1][0] = 7'd3;
    end

    function automatic logic [6:0] model_out(int d);
        logic [3:0] code;
        code = m_active[d] ? m_tbl[d][m_idx[d]][6:3] : 4'd0;
        return {m_active[d], m_active[d], m_done[d], code};
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            m_done[d] = 1'b0;
            if (rst) begin
                m_active[d] = 0; m_idx[d] = 0; m_el[d] = 0;
            end else if (!m_active[d]) begin
                if (start && !stop) begin
                    m_active[d] = 1; m_idx[d] = 0; m_el[d] = 0;
                end
            end else if (stop) begin
                m_active[d] = 0; m_idx[d] = 0; m_el[d] = 0;
            end else if (!pause) begin
                m_el[d]++;
                if (m_el[d] == (int'(m_tbl[d][m_idx[d]][2:0]) + 1) * m_tpb[d]) begin
                    m_el[d] = 0;
                    if (m_idx[d] == m_len[d] - 1) begin
                        m_idx[d] = 0;
                        m_done[d] = 1'b1;
                        if (!LOOP) m_active[d] = 0;
                    end else begin
                        m_idx[d]++;
                    end
                end
            end
        end
        #1;
        for (int d = 0; d < 3; d++) check("model", d, obs(d), model_out(d));
    end

    typedef struct {
        logic       rst, start, stop, pause;
        logic       valid, done;
        logic [3:0] code;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t idle_vec(logic r, logic s, logic p);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.pause = 1'b0;
        v.valid = 1'b0; v.done = 1'b0; v.code = 4'd0;
        return v;
    endfunction

    // Expected outputs p playing cycles after Start (TICKS_PER_BEAT=2, 16 one-beat entries).
    function automatic vec_t play_vec(int p, logic s, logic pz);
        vec_t v;
        v.rst = 1'b0; v.start = s; v.stop = 1'b0; v.pause = pz;
        if (LOOP) begin
            v.valid = 1'b1;
            v.code  = 4'((p % 32) / 2);
            v.done  = (p > 0) && (p % 32 == 0);
        end else begin
            v.valid = (p < 32);
            v.code  = (p < 32) ? 4'(p / 2) : 4'd0;
            v.done  = (p == 32);
        end
        return v;
    endfunction

    task automatic drive(input logic r, input logic s, input logic p, input logic pz);
        rst = r; start = s; stop = p; pause = pz;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset then idle
        for (int k = 0; k < 3; k++) vecs.push_back(idle_vec(1, 0, 0));
        for (int k = 0; k < 5; k++) vecs.push_back(idle_vec(0, 0, 0));
        // Full playback
        for (int k = 0; k < 34; k++) vecs.push_back(play_vec(k, k == 0, 0));
        vecs.push_back(idle_vec(0, 0, 1));
        vecs.push_back(idle_vec(0, 0, 0));
        // Pause for 5 cycles during entry 3
        for (int k = 0; k < 39; k++)
            vecs.push_back(play_vec((k < 7) ? k : (k <= 12 ? 6 : k - 5), k == 0, (k >= 7 && k <= 11)));
        vecs.push_back(idle_vec(0, 0, 1));
        vecs.push_back(idle_vec(0, 0, 0));
        // Ignored Start during PLAY, Stop during entry 9
        for (int k = 0; k < 19; k++) vecs.push_back(play_vec(k, k == 0 || k == 5, 0));
        vecs.push_back(idle_vec(0, 0, 1));
        for (int k = 0; k < 3; k++) vecs.push_back(idle_vec(0, 0, 0));
        // Start together with Stop in IDLE stays idle
        vecs.push_back(idle_vec(0, 1, 1));
        vecs.push_back(idle_vec(0, 0, 0));
        // Reset mid-playback
        for (int k = 0; k < 7; k++) vecs.push_back(play_vec(k, k == 0, 0));
        vecs.push_back(idle_vec(1, 1, 0));
        vecs.push_back(idle_vec(0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].pause);
            check("vector", 0, obs(0), {vecs[i].valid, vecs[i].valid, vecs[i].done, vecs[i].code});
        end

        // Custom duration: entry 0 has dur=3, so code 0 is held for 8 cycles
        for (int k = 0; k < 10; k++) begin
            drive(0, k == 0, 0, 0);
            check("custom_dur", 1, obs(1), {1'b1, 1'b1, 1'b0, (k < 8) ? 4'd0 : 4'd1});
        end
        drive(0, 0, 1, 0);
        check("custom_stop", 1, obs(1), 7'd0);

        // Randomized run; the model checks every cycle
        for (int k = 0; k < 3000; k++) begin
            logic pz;
            pz = pause;
            if ($urandom_range(11) == 0) pz = ~pz;
            drive($urandom_range(199) == 0, $urandom_range(5) == 0, $urandom_range(49) == 0, pz);
        end

        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
